axis_byte_fifo: RTL and testbench

//   Synchronous AXI4-Stream FIFO. Buffers a byte stream between a producer and the downstream
//   AXI4-Stream slave stage (8-bit TDATA, TVALID/TREADY only; no TLAST/TKEEP/TSTRB/TUSER).

---
 rtl/axis_byte_fifo.sv | 86 ++++++++
 tb/tb_axis_byte_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_fifo.sv
// axis_byte_fifo: synchronous first-word-fall-through AXI4-Stream byte FIFO.
// Absorbs downstream back-pressure so the producer can burst. The head entry is
// presented directly from storage. s_axis_tready is a flop and does not depend
// on m_axis_tready.
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   s_axis_tvalid/tready/tdata    slave (producer) side
//   m_axis_tvalid/tready/tdata    master (consumer) side
//   count                         current occupancy, 0..DEPTH
module axis_byte_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [DW-1:0] s_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = CW - 1;

    logic [DW-1:0] mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    assign push = s_axis_tvalid & s_axis_tready;
    assign pop  = m_axis_tvalid & m_axis_tready;

    // Occupancy after this cycle's handshakes.
    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    // Storage, pointers and the registered handshake flags.
    // The ready/valid flags are computed from next-cycle occupancy, so they
    // always match the occupancy register. s_axis_tready stays low through
    // reset and for the reset edge itself.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
                wr_ptr              <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            count         <= count_next;
            s_axis_tready <= (count_next != CW'(DEPTH));
            m_axis_tvalid <= (count_next != '0);
        end
    end

    // FWFT head. A push can only target the head slot when the FIFO is empty,
    // so the presented word never changes during a stall.
    assign m_axis_tdata = mem[rd_ptr[AW-1:0]];

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge aclk) count <= CW'(DEPTH));
    a_no_push_full: assert property (@(posedge aclk)
        !(s_axis_tvalid && s_axis_tready && count == CW'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge aclk)
        !(m_axis_tvalid && m_axis_tready && count == '0));
    a_stall_stable: assert property (@(posedge aclk)
        (!areset && m_axis_tvalid && !m_axis_tready) |=> (m_axis_tvalid && $stable(m_axis_tdata)));
`endif

endmodule

// File: tb/tb_axis_byte_fifo.sv
// Bench for axis_byte_fifo: one DEPTH=16 and one DEPTH=4 instance, directed
// stimulus plus a scoreboard monitor that models occupancy and order.
module tb_axis_byte_fifo;

    logic       aclk = 1'b0;
    logic       areset;
    logic       svalid [2];
    logic       sready [2];
    logic [7:0] sdata  [2];
    logic       mvalid [2];
    logic       mready [2];
    logic [7:0] mdata  [2];
    logic [4:0] cnt16;
    logic [2:0] cnt4;
    int         cnt    [2];

    logic [7:0] q [2][$];
    bit         rst_prev = 1'b0;
    bit         rnd_run  = 1'b0;
    int         checks   = 0;
    int         errors   = 0;

    always #5 aclk = ~aclk;

    axis_byte_fifo #(.DW(8), .DEPTH(16)) dut16 (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(svalid[0]), .s_axis_tready(sready[0]), .s_axis_tdata(sdata[0]),
        .m_axis_tvalid(mvalid[0]), .m_axis_tready(mready[0]), .m_axis_tdata(mdata[0]),
        .count(cnt16)
    );

    axis_byte_fifo #(.DW(8), .DEPTH(4)) dut4 (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(svalid[1]), .s_axis_tready(sready[1]), .s_axis_tdata(sdata[1]),
        .m_axis_tvalid(mvalid[1]), .m_axis_tready(mready[1]), .m_axis_tdata(mdata[1]),
        .count(cnt4)
    );

    assign cnt[0] = int'(cnt16);
    assign cnt[1] = int'(cnt4);

    function automatic int depth_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d got 0x%0h expected 0x%0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: state checks against the queue model, then apply handshakes.
    always @(negedge aclk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_prev) begin
                chk("rst_sready", i, int'(sready[i]), 0);
                chk("rst_mvalid", i, int'(mvalid[i]), 0);
                chk("rst_count",  i, cnt[i], 0);
                chk("rst_mdata",  i, int'(mdata[i]), 0);
            end else if (!areset) begin
                chk("count",  i, cnt[i], q[i].size());
                chk("mvalid", i, int'(mvalid[i]), int'(q[i].size() != 0));
                chk("sready", i, int'(sready[i]), int'(q[i].size() != depth_of(i)));
                if (q[i].size() != 0)
                    chk("mdata", i, int'(mdata[i]), int'(q[i][0]));
            end
            if (areset) begin
                q[i].delete();
            end else begin
                if (mvalid[i] && mready[i]) begin
                    if (q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_empty inst%0d got pop expected none at %0t", i, $time);
                    end else begin
                        void'(q[i].pop_front());
                    end
                end
                if (svalid[i] && sready[i])
                    q[i].push_back(sdata[i]);
            end
        end
        rst_prev = areset;
    end

    // Hold svalid/sdata until accepted; returns #1 after the accepting edge.
    task automatic send(input int i, input logic [7:0] d);
        int  n    = 0;
        bit  done = 1'b0;
        svalid[i] = 1'b1;
        sdata[i]  = d;
        while (!done) begin
            @(negedge aclk);
            done = sready[i] && !areset;
            @(posedge aclk);
            #1;
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout inst%0d got no ready expected accept of 0x%0h", i, d);
                done = 1'b1;
            end
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic rand_drive(input int i);
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                svalid[i] = 1'b0;
                cycles(1);
            end
            send(i, 8'($urandom));
        end
        svalid[i] = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        mready[0] = 1'b1;
        mready[1] = 1'b1;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
            cycles(1);
            n++;
        end
        cycles(1);
        chk("drain_q0", 0, q[0].size(), 0);
        chk("drain_q1", 1, q[1].size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with the producer pushing 0xAA: nothing must be stored.
        areset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            svalid[i] = 1'b0; sdata[i] = 8'h00; mready[i] = 1'b0;
        end
        svalid[0] = 1'b1;
        sdata[0]  = 8'hAA;
        cycles(3);
        chk("reset_sready", 0, int'(sready[0]), 0);
        chk("reset_count",  0, cnt[0], 0);
        chk("reset_mvalid", 0, int'(mvalid[0]), 0);
        chk("reset_mdata",  0, int'(mdata[0]), 0);
        areset    = 1'b0;
        svalid[0] = 1'b0;
        cycles(1);
        chk("ready_after_reset", 0, int'(sready[0]), 1);
        chk("count_after_reset", 0, cnt[0], 0);

        // Single byte straight through.
        mready[0] = 1'b1;
        send(0, 8'h5A);
        svalid[0] = 1'b0;
        chk("single_mvalid", 0, int'(mvalid[0]), 1);
        chk("single_mdata",  0, int'(mdata[0]), 8'h5A);
        cycles(1);
        chk("single_count",  0, cnt[0], 0);

        // Fill with the consumer stalled, then offer a 17th byte.
        mready[0] = 1'b0;
        for (int k = 0; k < 16; k++) send(0, 8'(k));
        chk("full_count",  0, cnt[0], 16);
        chk("full_sready", 0, int'(sready[0]), 0);
        sdata[0] = 8'h10;
        cycles(3);
        chk("full_hold_count", 0, cnt[0], 16);
        chk("full_hold_mdata", 0, int'(mdata[0]), 8'h00);

        // One pop at full; ready returns the following cycle and 0x10 goes in.
        mready[0] = 1'b1;
        cycles(1);
        mready[0] = 1'b0;
        chk("pop_at_full_count",  0, cnt[0], 15);
        chk("pop_at_full_sready", 0, int'(sready[0]), 1);
        chk("pop_at_full_mdata",  0, int'(mdata[0]), 8'h01);
        send(0, 8'h10);
        svalid[0] = 1'b0;
        chk("refill_count", 0, cnt[0], 16);
        drain_all();
        mready[1] = 1'b0;

        // Streaming, both sides always ready: occupancy holds at one.
        mready[0] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            send(0, 8'(k));
            chk("stream_count", 0, cnt[0], 1);
        end
        svalid[0] = 1'b0;
        drain_all();

        // Random traffic on both depths with a mid-run reset pulse.
        rnd_run = 1'b1;
        fork
            while (rnd_run) begin
                mready[0] = 1'($urandom_range(0, 1));
                mready[1] = 1'($urandom_range(0, 1));
                cycles(1);
            end
        join_none
        fork
            rand_drive(0);
            rand_drive(1);
            begin
                cycles(700);
                areset = 1'b1;
                cycles(1);
                areset = 1'b0;
            end
        join
        rnd_run = 1'b0;
        cycles(2);
        drain_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
